// File: rtl/rf_read_arbiter_if.sv
// Request/grant/return bundle between the read-port arbiter and its requesters plus the register-file mux.
// master = requesters and register file, slave = arbiter.
interface rf_read_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0]      rf_sel;
    logic [DATA_W-1:0]      rf_data;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rd_valid;
    logic [DATA_W-1:0]      rd_data;
    logic [NREQ-1:0]        pending;
    logic                   overrun;

    modport master (
        output req, req_addr, rf_data,
        input  rf_sel, gnt, rd_valid, rd_data, pending, overrun
    );

    modport slave (
        input  req, req_addr, rf_data,
        output rf_sel, gnt, rd_valid, rd_data, pending, overrun
    );
endinterface

// File: rtl/rf_read_arbiter.sv
// Round-robin sharing of one register-file read port: one buffered request per requester,
// one grant per cycle, registered data returned with a per-requester valid pulse.
module rf_read_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input logic               clock,
    input logic               reset,
    rf_read_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0]  ptr;
    logic [ADDR_W-1:0] addr_q [NREQ];
    logic [NREQ-1:0]   pending_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   rd_valid_q;
    logic [ADDR_W-1:0] rf_sel_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              overrun_q;

    logic              win_vld;
    logic [PTR_W-1:0]  win_idx;
    logic [NREQ-1:0]   win_oh;

    // Index arithmetic modulo NREQ, which need not be a power of two.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return PTR_W'(s);
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_vld && pending_q[wrap_add(ptr, k)]) begin
                win_vld = 1'b1;
                win_idx = wrap_add(ptr, k);
            end
        end
        win_oh = win_vld ? (NREQ'(1) << win_idx) : '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the small address buffer is reset too, keeping rf_sel free of X after the first grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q  <= '0;
            gnt_q      <= '0;
            rd_valid_q <= '0;
            overrun_q  <= 1'b0;
            rf_sel_q   <= '0;
            rd_data_q  <= '0;
            ptr        <= '0;
            for (int i = 0; i < NREQ; i++) addr_q[i] <= '0;
        end else begin
            // A new request overrides a same-edge grant clear; otherwise a pending slot drops it.
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req[i] && (!pending_q[i] || win_oh[i]))
                    addr_q[i] <= bus.req_addr[i*ADDR_W +: ADDR_W];
            end
            pending_q <= bus.req | (pending_q & ~win_oh);
            overrun_q <= |(bus.req & pending_q & ~win_oh);

            gnt_q <= win_oh;
            if (win_vld) begin
                rf_sel_q <= addr_q[win_idx];
                ptr      <= wrap_add(win_idx, 1);
            end

            rd_valid_q <= gnt_q;
            if (|gnt_q) rd_data_q <= bus.rf_data;
        end
    end

    assign bus.rf_sel   = rf_sel_q;
    assign bus.gnt      = gnt_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.pending  = pending_q;
    assign bus.overrun  = overrun_q;
endmodule
